// File: rtl/time_display_scan.sv
// time_display_scan: six-digit multiplexed seven-segment driver for the clock.
// Splits a coherent per-frame snapshot of hour/min/sec into BCD digits, lights
// one digit per slot after a single blank cycle, and blinks the field being edited.
module time_display_scan #(
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 500000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [4:0] TIME_HOUR,
    input  logic [5:0] TIME_MIN,
    input  logic [5:0] TIME_SEC,
    input  logic [1:0] SET_FIELD,
    output logic [5:0] SEG_COM,
    output logic [7:0] SEG_DATA
);

    localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SW-1:0] SCAN_TC  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_DIV - 1);

    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]    digit_idx_q, digit_idx_d;
    logic          load_q, load_d;
    logic [4:0]    snap_hour_q, snap_hour_d;
    logic [5:0]    snap_min_q, snap_min_d;
    logic [5:0]    snap_sec_q, snap_sec_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;
    logic [1:0]    set_field_q, set_field_d;
    logic [5:0]    seg_com_q, seg_com_d;
    logic [7:0]    seg_data_q, seg_data_d;

    logic          tick;
    logic          field_change;
    logic          blink_now;
    logic [5:0]    field_val;
    logic          field_ok;
    logic [1:0]    field_id;
    logic [5:0]    bcd_rem;
    logic [3:0]    bcd_tens;
    logic [5:0]    digit_val;
    logic [6:0]    seg_code;
    logic          dp;
    logic          blank;
    logic [7:0]    lit_data;

    assign tick = (scan_cnt_q == SCAN_TC);

    // Slot timer, digit index and frame snapshot taken when the index wraps to 0
    always_comb begin
        scan_cnt_d  = tick ? '0 : scan_cnt_q + 1'b1;
        digit_idx_d = digit_idx_q;
        load_d      = tick;
        snap_hour_d = snap_hour_q;
        snap_min_d  = snap_min_q;
        snap_sec_d  = snap_sec_q;
        if (tick) begin
            if (digit_idx_q == 3'd5) begin
                digit_idx_d = 3'd0;
                snap_hour_d = TIME_HOUR;
                snap_min_d  = TIME_MIN;
                snap_sec_d  = TIME_SEC;
            end else begin
                digit_idx_d = digit_idx_q + 3'd1;
            end
        end
    end

    // Blink timer; a change of edited field restarts it in the visible phase
    always_comb begin
        field_change  = (set_field_q != SET_FIELD);
        set_field_d   = SET_FIELD;
        blink_cnt_d   = blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q;
        if (field_change) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (blink_cnt_q == BLINK_TC) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
        // A load in the same clock as a field change must already see the field lit
        blink_now = field_change ? 1'b0 : blink_phase_q;
    end

    // Field select for the current digit and binary-to-BCD by repeated subtraction
    always_comb begin
        field_val = {1'b0, snap_hour_q};
        field_ok  = (snap_hour_q <= 5'd23);
        field_id  = 2'd1;
        case (digit_idx_q)
            3'd0, 3'd1: begin
                field_val = snap_sec_q;
                field_ok  = (snap_sec_q <= 6'd59);
                field_id  = 2'd3;
            end
            3'd2, 3'd3: begin
                field_val = snap_min_q;
                field_ok  = (snap_min_q <= 6'd59);
                field_id  = 2'd2;
            end
            default: ;
        endcase
        bcd_rem  = field_val;
        bcd_tens = 4'd0;
        for (int i = 0; i < 6; i++) begin
            if (bcd_rem >= 6'd10) begin
                bcd_rem  = bcd_rem - 6'd10;
                bcd_tens = bcd_tens + 4'd1;
            end
        end
        digit_val = digit_idx_q[0] ? {2'b00, bcd_tens} : bcd_rem;
    end

    // Segment encoding, separator dots and blink blanking for the digit to load
    always_comb begin
        case (digit_val)
            6'd0:    seg_code = 7'h3F;
            6'd1:    seg_code = 7'h06;
            6'd2:    seg_code = 7'h5B;
            6'd3:    seg_code = 7'h4F;
            6'd4:    seg_code = 7'h66;
            6'd5:    seg_code = 7'h6D;
            6'd6:    seg_code = 7'h7D;
            6'd7:    seg_code = 7'h07;
            6'd8:    seg_code = 7'h7F;
            6'd9:    seg_code = 7'h6F;
            default: seg_code = 7'h00;
        endcase
        dp       = (digit_idx_q == 3'd2) || (digit_idx_q == 3'd4);
        blank    = blink_now && (SET_FIELD == field_id);
        lit_data = {dp, blank ? 7'h00 : (field_ok ? seg_code : 7'h40)};
    end

    // Output registers: blank on the tick, load the new digit one clock later
    always_comb begin
        seg_com_d  = seg_com_q;
        seg_data_d = seg_data_q;
        if (tick) begin
            seg_com_d  = 6'h3F;
            seg_data_d = 8'h00;
        end else if (load_q) begin
            seg_com_d  = ~(6'd1 << digit_idx_q);
            seg_data_d = lit_data;
        end
    end

    // State registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            scan_cnt_q    <= '0;
            digit_idx_q   <= 3'd5;
            load_q        <= 1'b0;
            snap_hour_q   <= '0;
            snap_min_q    <= '0;
            snap_sec_q    <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            set_field_q   <= 2'd0;
            seg_com_q     <= 6'h3F;
            seg_data_q    <= 8'h00;
        end else begin
            scan_cnt_q    <= scan_cnt_d;
            digit_idx_q   <= digit_idx_d;
            load_q        <= load_d;
            snap_hour_q   <= snap_hour_d;
            snap_min_q    <= snap_min_d;
            snap_sec_q    <= snap_sec_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            set_field_q   <= set_field_d;
            seg_com_q     <= seg_com_d;
            seg_data_q    <= seg_data_d;
        end
    end

    assign SEG_COM  = seg_com_q;
    assign SEG_DATA = seg_data_q;

endmodule

// File: tb/tb_time_display_scan.sv
// Scoreboard bench for time_display_scan: expected digit loads are queued by the
// stimulus and consumed by a monitor each time a new digit lights up.
module tb_time_display_scan;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 64;

    // Frames packed as {d5,d4,d3,d2,d1,d0}
    localparam logic [47:0] F_123456 = {8'h06, 8'hDB, 8'h4F, 8'hE6, 8'h6D, 8'h7D};
    localparam logic [47:0] F_235959 = {8'h5B, 8'hCF, 8'h6D, 8'hEF, 8'h6D, 8'h6F};
    localparam logic [47:0] F_246007 = {8'h40, 8'hC0, 8'h40, 8'hC0, 8'h3F, 8'h07};

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [4:0] TIME_HOUR;
    logic [5:0] TIME_MIN;
    logic [5:0] TIME_SEC;
    logic [1:0] SET_FIELD;
    logic [5:0] SEG_COM;
    logic [7:0] SEG_DATA;

    typedef struct {
        logic [5:0] com;
        logic [7:0] data;
        int         tag;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pops   = 0;
    int   base;

    time_display_scan #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
        .CLK(CLK), .RST(RST),
        .TIME_HOUR(TIME_HOUR), .TIME_MIN(TIME_MIN), .TIME_SEC(TIME_SEC),
        .SET_FIELD(SET_FIELD),
        .SEG_COM(SEG_COM), .SEG_DATA(SEG_DATA)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic push_slot(input int tag, input int idx, input logic [7:0] data);
        exp_t e;
        e.com  = ~(6'd1 << idx);
        e.data = data;
        e.tag  = tag;
        sb_q.push_back(e);
    endtask

    task automatic push_frame(input int tag, input logic [47:0] f);
        for (int k = 0; k < 6; k++) push_slot(tag, k, f[8*k +: 8]);
    endtask

    // Bounded wait until the monitor has consumed 'target' digit loads in total
    task automatic wait_pops(input int target, input string name);
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            #1;
            if (pops >= target) return;
        end
        checks++;
        errors++;
        $display("FAIL %s timeout pops=%0d exp=%0d", name, pops, target);
    endtask

    // Expected slot m of a blink run (m counts digit loads since reset release).
    // Load edge e = 5+4m uses the phase held after edge e-1; the blink counter was
    // last cleared at edge c, so that phase is ((e-1-c)/64) mod 2.
    function automatic logic [7:0] blink_exp(input int m, input int sf, input int c);
        logic [47:0] f;
        int k, e, ph, fld;
        f   = F_123456;
        k   = m % 6;
        e   = 5 + 4 * m;
        ph  = ((e - 1 - c) / BLINK_DIV) % 2;
        fld = (k < 2) ? 3 : ((k < 4) ? 2 : 1);
        if (ph == 1 && fld == sf) return (k == 2 || k == 4) ? 8'h80 : 8'h00;
        return f[8*k +: 8];
    endfunction

    // Monitor: every blank->lit transition is one digit load to score
    initial begin
        logic [5:0] prev;
        exp_t e;
        prev = 6'h3F;
        forever begin
            @(negedge CLK);
            if (RST) begin
                prev = 6'h3F;
            end else begin
                if (prev == 6'h3F && SEG_COM != 6'h3F) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_load got com=%h data=%h exp=none", SEG_COM, SEG_DATA);
                    end else begin
                        e = sb_q.pop_front();
                        if (SEG_COM !== e.com || SEG_DATA !== e.data) begin
                            errors++;
                            $display("FAIL load tag=%0d load=%0d got com=%h data=%h exp com=%h data=%h",
                                     e.tag, pops, SEG_COM, SEG_DATA, e.com, e.data);
                        end
                    end
                    pops++;
                end
                prev = SEG_COM;
            end
        end
    end

    task automatic enter_reset();
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        TIME_HOUR = h;
        TIME_MIN  = m;
        TIME_SEC  = s;
    endtask

    initial begin
        set_time(5'd12, 6'd34, 6'd56);
        SET_FIELD = 2'd0;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        #1;
        check("reset_com", {2'b00, SEG_COM}, 8'h3F);
        check("reset_data", SEG_DATA, 8'h00);

        // Normal scan, then a mid-frame input change that must not tear the frame
        push_frame(1, F_123456);
        push_frame(1, F_123456);
        push_frame(2, F_123456);
        push_frame(2, F_235959);
        base = pops;
        @(negedge CLK);
        RST = 1'b0;
        repeat (SCAN_DIV) @(posedge CLK);
        #1;
        check("first_tick_com", {2'b00, SEG_COM}, 8'h3F);
        @(posedge CLK);
        #1;
        check("first_lit_com", {2'b00, SEG_COM}, 8'h3E);
        check("first_lit_data", SEG_DATA, 8'h7D);
        @(posedge CLK);
        #1;
        check("hold_com", {2'b00, SEG_COM}, 8'h3E);
        wait_pops(base + 15, "mid_frame_trigger");
        set_time(5'd23, 6'd59, 6'd59);
        wait_pops(base + 24, "coherent_frames");

        // Out-of-range hour and minute show dashes, seconds unaffected
        enter_reset();
        set_time(5'd24, 6'd60, 6'd7);
        push_frame(3, F_246007);
        base = pops;
        @(negedge CLK);
        RST = 1'b0;
        wait_pops(base + 6, "out_of_range");

        // Blink minutes, then switch to seconds which restarts the half-period
        enter_reset();
        set_time(5'd12, 6'd34, 6'd56);
        SET_FIELD = 2'd2;
        for (int m = 0; m < 50; m++) push_slot(4, m % 6, blink_exp(m, 2, 1));
        base = pops;
        @(negedge CLK);
        RST = 1'b0;
        wait_pops(base + 50, "blink_min");
        SET_FIELD = 2'd3;
        for (int m = 50; m < 84; m++) push_slot(5, m % 6, blink_exp(m, 3, 202));
        wait_pops(base + 84, "blink_sec");

        // Asynchronous reset in the middle of a lit slot
        enter_reset();
        SET_FIELD = 2'd0;
        for (int k = 0; k < 3; k++) push_slot(6, k, blink_exp(k, 0, 1));
        base = pops;
        @(negedge CLK);
        RST = 1'b0;
        wait_pops(base + 3, "pre_async_reset");
        #1;
        RST = 1'b1;
        #1;
        check("async_rst_com", {2'b00, SEG_COM}, 8'h3F);
        check("async_rst_data", SEG_DATA, 8'h00);
        check("async_rst_queue", 8'(sb_q.size()), 8'd0);
        @(negedge CLK);
        push_frame(7, F_123456);
        @(negedge CLK);
        RST = 1'b0;
        repeat (SCAN_DIV) @(posedge CLK);
        #1;
        check("rst_restart_blank", {2'b00, SEG_COM}, 8'h3F);
        @(posedge CLK);
        #1;
        check("rst_restart_com", {2'b00, SEG_COM}, 8'h3E);
        check("rst_restart_data", SEG_DATA, 8'h7D);
        wait_pops(base + 9, "post_reset_frame");

        check("leftover_expected", 8'(sb_q.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
